// File: rtl/arm_defs.sv
// Shared definitions for the ARM pipeline: memory-stage FSM encoding and
// default data-memory geometry.
package arm_defs;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_MEM_WORDS   = 64;
  localparam int DEF_WAIT_CYCLES = 4;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous write, asynchronous read, no reset of
// contents.
module data_memory
  import arm_defs::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] idx,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: wait-stated access to the data RAM with an upstream stall,
// followed by the MEM/WB pipeline register.
module mem_stage
  import arm_defs::*;
#(
  parameter int MEM_WORDS   = DEF_MEM_WORDS,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        freeze,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic [31:0] alu_result,
  output logic [31:0] mem_data,
  output logic [3:0]  dest
);

  localparam int              AW       = $clog2(MEM_WORDS);
  localparam int              CNT_W    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0]     BASE     = 32'(BASE_ADDR);

  // Handshake: upstream holds every input stable while freeze is high; the
  // access completes in DONE, where freeze drops and the result is captured.

  ms_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req;
  logic        in_range;
  logic        mem_we;
  logic [29:0] idx;
  logic [31:0] ram_rdata;
  logic [31:0] rd_data;

  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [3:0]  dest_q, dest_d;

  assign req = mem_r_en_in | mem_w_en_in;

  // Address offset is unsigned; the low two byte bits are dropped.
  assign idx      = 30'((alu_result_in - BASE) >> 2);
  assign in_range = (alu_result_in >= BASE) && (idx < 30'(MEM_WORDS));
  assign rd_data  = in_range ? ram_rdata : 32'd0;

  data_memory #(
    .MEM_WORDS(MEM_WORDS)
  ) u_data_memory (
    .clk  (clk),
    .we   (mem_we),
    .idx  (idx[AW-1:0]),
    .wdata(val_rm_in),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (req) begin
          state_d = MS_WAIT;
          cnt_d   = '0;
        end
      end
      MS_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = MS_DONE;
          mem_we  = mem_w_en_in & in_range & ~rst;
        end
      end
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  assign freeze = req & (state_q != MS_DONE);

  // A frozen cycle inserts a bubble but keeps the data fields.
  always_comb begin
    wb_en_d      = wb_en_in;
    mem_r_en_d   = mem_r_en_in;
    alu_result_d = alu_result_in;
    mem_data_d   = rd_data;
    dest_d       = dest_in;
    if (freeze) begin
      wb_en_d      = 1'b0;
      mem_r_en_d   = 1'b0;
      alu_result_d = alu_result_q;
      mem_data_d   = mem_data_q;
      dest_d       = dest_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MS_IDLE;
      cnt_q        <= '0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      alu_result_q <= 32'd0;
      mem_data_q   <= 32'd0;
      dest_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_en_q      <= wb_en_d;
      mem_r_en_q   <= mem_r_en_d;
      alu_result_q <= alu_result_d;
      mem_data_q   <= mem_data_d;
      dest_q       <= dest_d;
    end
  end

  assign wb_en      = wb_en_q;
  assign mem_r_en   = mem_r_en_q;
  assign alu_result = alu_result_q;
  assign mem_data   = mem_data_q;
  assign dest       = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reference memory model, expected-result
// queue, and immediate-assertion checks on every observed result.
module tb_mem_stage;
  import arm_defs::*;

  localparam int WC    = 4;
  localparam int BASE  = 1024;
  localparam int WORDS = 64;
  localparam int W     = 70;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_result_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        freeze, wb_en, mem_r_en;
  logic [31:0] alu_result, mem_data;
  logic [3:0]  dest;

  logic [W-1:0] exp_q[$];
  logic [31:0]  ref_mem [WORDS];
  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage #(
    .MEM_WORDS  (WORDS),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .alu_result_in(alu_result_in),
    .val_rm_in    (val_rm_in),
    .dest_in      (dest_in),
    .freeze       (freeze),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .alu_result   (alu_result),
    .mem_data     (mem_data),
    .dest         (dest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] out_vec();
    return {wb_en, mem_r_en, alu_result, mem_data, dest};
  endfunction

  // Reference memory: applies a store, then returns what a read of that
  // address yields (0 when out of range).
  task automatic model_access(input logic w, input logic [31:0] addr,
                              input logic [31:0] data, output logic [31:0] rd);
    logic [31:0] word;
    word = (addr - 32'(BASE)) >> 2;
    rd = 32'd0;
    if (addr >= 32'(BASE) && word < 32'(WORDS)) begin
      if (w) ref_mem[word[5:0]] = data;
      rd = ref_mem[word[5:0]];
    end
  endtask

  task automatic drive_nop();
    wb_en_in      = 1'b0;
    mem_r_en_in   = 1'b0;
    mem_w_en_in   = 1'b0;
    alu_result_in = 32'd0;
    val_rm_in     = 32'd0;
    dest_in       = 4'd0;
  endtask

  task automatic run_instr(input string tag, input logic wb, input logic r, input logic w,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] dst);
    int frz;
    int lat;
    logic req;
    logic [31:0] md;
    @(negedge clk);
    wb_en_in      = wb;
    mem_r_en_in   = r;
    mem_w_en_in   = w;
    alu_result_in = addr;
    val_rm_in     = data;
    dest_in       = dst;
    req = r | w;
    model_access(w, addr, data, md);
    exp_q.push_back({wb, r, addr, md, dst});
    #1;
    frz = 0;
    lat = 0;
    while (freeze && frz < 20) begin
      frz++;
      if (frz >= 2) check({tag, "_bubble"}, W'({wb_en, mem_r_en}), W'(2'b00));
      @(negedge clk);
      #1;
      lat++;
    end
    check({tag, "_freeze_len"}, W'(frz), W'(req ? WC + 1 : 0));
    @(negedge clk);
    lat++;
    drive_nop();
    #1;
    check({tag, "_latency"}, W'(lat), W'(req ? WC + 2 : 1));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, W'(0), W'(1));
    end else begin
      check({tag, "_result"}, out_vec(), exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_nop();
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", out_vec(), W'(0));
    check("reset_freeze", W'(freeze), W'(0));
    check("reset_state", W'(dut.state_q), W'(MS_IDLE));
    check("reset_cnt", W'(dut.cnt_q), W'(0));
    rst = 1'b0;

    run_instr("alu_53", 1'b1, 1'b0, 1'b0, 32'd53, 32'd0, 4'd4);
    run_instr("store_85", 1'b0, 1'b0, 1'b1, 32'd1024, 32'd85, 4'd0);
    run_instr("load_85", 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd2);

    run_instr("store_top", 1'b0, 1'b0, 1'b1, 32'd1024 + 4 * 63, 32'hDEADBEEF, 4'd0);
    run_instr("load_unaligned", 1'b1, 1'b1, 1'b0, 32'd1026 + 4 * 63, 32'd0, 4'd9);

    run_instr("store_below", 1'b0, 1'b0, 1'b1, 32'd1020, 32'h1111_1111, 4'd0);
    run_instr("store_above", 1'b0, 1'b0, 1'b1, 32'd1024 + 4 * 64, 32'h2222_2222, 4'd0);
    run_instr("load_word0", 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd1);
    run_instr("load_word63", 1'b1, 1'b1, 1'b0, 32'd1024 + 4 * 63, 32'd0, 4'd3);
    run_instr("load_below", 1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 4'd5);
    run_instr("load_above", 1'b1, 1'b1, 1'b0, 32'd1024 + 4 * 64, 32'd0, 4'd6);

    // Reset in the second WAIT cycle of a store must leave word 5 untouched.
    run_instr("store_w5_old", 1'b0, 1'b0, 1'b1, 32'd1044, 32'd3, 4'd0);
    run_instr("load_w5_pre", 1'b1, 1'b1, 1'b0, 32'd1044, 32'd0, 4'd8);
    @(negedge clk);
    wb_en_in      = 1'b0;
    mem_r_en_in   = 1'b0;
    mem_w_en_in   = 1'b1;
    alu_result_in = 32'd1044;
    val_rm_in     = 32'd7;
    dest_in       = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive_nop();
    @(negedge clk);
    #1;
    check("abort_state", W'(dut.state_q), W'(MS_IDLE));
    check("abort_outputs", out_vec(), W'(0));
    check("abort_freeze", W'(freeze), W'(0));
    rst = 1'b0;
    run_instr("load_w5_post", 1'b1, 1'b1, 1'b0, 32'd1044, 32'd0, 4'd10);

    run_instr("rw_both", 1'b1, 1'b1, 1'b1, 32'd1028, 32'd9, 4'd7);
    run_instr("load_w1", 1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd11);

    for (int i = 0; i < 4; i++) begin
      run_instr("alu_rand", 1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 1023)), 32'd0,
                4'($urandom_range(0, 15)));
    end
    run_instr("store_rand", 1'b0, 1'b0, 1'b1, 32'd1024 + 4 * 32'($urandom_range(0, 63)),
              $urandom, 4'd0);

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
